// File: rtl/uart_pkg.sv
// Shared types, FSM state encodings and parity helper for the UART transceiver.
package uart_pkg;

    localparam int unsigned UART_MAX_DATA = 9;
    localparam int unsigned STATE_W       = 3;

    typedef logic [STATE_W-1:0] tx_state_t;
    typedef logic [STATE_W-1:0] rx_state_t;

    localparam tx_state_t T_IDLE   = 3'd0;
    localparam tx_state_t T_START  = 3'd1;
    localparam tx_state_t T_DATA   = 3'd2;
    localparam tx_state_t T_PARITY = 3'd3;
    localparam tx_state_t T_STOP   = 3'd4;

    localparam rx_state_t R_IDLE   = 3'd0;
    localparam rx_state_t R_START  = 3'd1;
    localparam rx_state_t R_DATA   = 3'd2;
    localparam rx_state_t R_PARITY = 3'd3;
    localparam rx_state_t R_STOP   = 3'd4;

    // Sized for the widest character; narrower characters are zero-extended.
    typedef struct packed {
        logic                     parity_err;
        logic                     frame_err;
        logic [UART_MAX_DATA-1:0] data;
    } rx_entry_t;

    function automatic logic uart_parity(input logic [UART_MAX_DATA-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; head word and valid are registered.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full_c,
    output logic             empty_c,
    output logic             drop_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic             push_eff, pop_eff;
    logic [WIDTH-1:0] head_d;

    assign empty_c  = (wr_q == rd_q);
    assign full_c   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_eff  = pop && !empty_c;
    assign push_eff = push && (!full_c || pop_eff);
    assign drop_c   = push && full_c && !pop_eff;
    assign wr_d     = wr_q + (AW+1)'(push_eff);
    assign rd_d     = rd_q + (AW+1)'(pop_eff);

    // A word pushed into the slot that becomes head is not in mem yet, so bypass it.
    always_comb begin
        head_d = mem[rd_d[AW-1:0]];
        if (push_eff && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            head_data  <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            head_data  <= head_d;
            head_valid <= (wr_d != rd_d);
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX serialiser and 16x-oversampled RX deserialiser feeding an error-tagged FIFO.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  tx_busy_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  rx_parity_err_o,
    output logic                  rx_frame_err_o,
    output logic                  rx_overrun_o,
    input  logic                  rx_overrun_clr_i,
    output logic                  tx_o,
    input  logic                  rx_i
);
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    logic [DIV_WIDTH-1:0] div_eff_c;
    assign div_eff_c = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;

    // ---------------- TX ----------------
    tx_state_t             tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0]  tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [OS_W-1:0]       tx_os_q, tx_os_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d, tx_d;
    logic                  tx_tick_c, tx_done_c;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_div_d    = tx_div_q;
        tx_cnt_d    = tx_cnt_q;
        tx_os_d     = tx_os_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        tx_d        = tx_o;
        tx_tick_c   = (tx_cnt_q >= tx_div_q - DIV_WIDTH'(1));
        tx_done_c   = tx_tick_c && (tx_os_q == OS_W'(OVERSAMPLE - 1));
        if (tx_state_q != T_IDLE) begin
            tx_cnt_d = tx_tick_c ? '0 : tx_cnt_q + DIV_WIDTH'(1);
            if (tx_tick_c) tx_os_d = tx_done_c ? '0 : tx_os_q + OS_W'(1);
        end
        case (tx_state_q)
            T_IDLE: if (tx_valid_i) begin
                tx_state_d  = T_START;
                tx_div_d    = div_eff_c;
                tx_cnt_d    = '0;
                tx_os_d     = '0;
                tx_shift_d  = tx_data_i;
                tx_par_en_d = parity_en_i;
                tx_par_d    = uart_parity(UART_MAX_DATA'(tx_data_i), parity_odd_i);
                tx_d        = 1'b0;
            end
            T_START: if (tx_done_c) begin
                tx_state_d = T_DATA;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            T_DATA: if (tx_done_c) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_d       = tx_shift_q[1];
                tx_bit_d   = tx_bit_q + BIT_W'(1);
                if (tx_bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                    tx_bit_d   = '0;
                    tx_state_d = tx_par_en_q ? T_PARITY : T_STOP;
                    tx_d       = tx_par_en_q ? tx_par_q : 1'b1;
                end
            end
            T_PARITY: if (tx_done_c) begin
                tx_state_d = T_STOP;
                tx_d       = 1'b1;
            end
            T_STOP: if (tx_done_c) begin
                tx_bit_d = tx_bit_q + BIT_W'(1);
                if (tx_bit_q == BIT_W'(STOP_BITS - 1)) tx_state_d = T_IDLE;
            end
            default: begin
                tx_state_d = T_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= T_IDLE;
            tx_div_q    <= DIV_WIDTH'(1);
            tx_cnt_q    <= '0;
            tx_os_q     <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_o        <= 1'b1;
            tx_ready_o  <= 1'b1;
            tx_busy_o   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_div_q    <= tx_div_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_os_q     <= tx_os_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
            tx_o        <= tx_d;
            tx_ready_o  <= (tx_state_d == T_IDLE);
            tx_busy_o   <= (tx_state_d != T_IDLE);
        end
    end

    // ---------------- RX ----------------
    logic                  rx_s1, rx_s2, rx_prev;
    rx_state_t             rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0]  rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [OS_W-1:0]       rx_os_q, rx_os_d;
    logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic                  rx_par_bit_q, rx_par_bit_d;
    logic                  rx_tick_c, rx_half_c, rx_done_c, push_c;
    rx_entry_t             push_entry_c;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_div_d     = rx_div_q;
        rx_os_d      = rx_os_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_par_bit_d = rx_par_bit_q;
        push_c       = 1'b0;
        push_entry_c = '0;
        rx_tick_c    = (rx_cnt_q >= rx_div_q - DIV_WIDTH'(1));
        rx_half_c    = rx_tick_c && (rx_os_q == OS_W'(OVERSAMPLE / 2 - 1));
        rx_done_c    = rx_tick_c && (rx_os_q == OS_W'(OVERSAMPLE - 1));
        rx_cnt_d     = rx_tick_c ? '0 : rx_cnt_q + DIV_WIDTH'(1);
        if (rx_state_q != R_IDLE && rx_tick_c) rx_os_d = rx_os_q + OS_W'(1);
        case (rx_state_q)
            R_IDLE: begin
                rx_div_d = div_eff_c;
                if (rx_prev && !rx_s2) begin
                    rx_state_d   = R_START;
                    rx_cnt_d     = '0;
                    rx_os_d      = '0;
                    rx_par_en_d  = parity_en_i;
                    rx_par_odd_d = parity_odd_i;
                end
            end
            R_START: if (rx_half_c) begin
                rx_os_d    = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_done_c) begin
                rx_os_d    = '0;
                rx_shift_d = {rx_s2, rx_shift_q[DATA_WIDTH-1:1]};
                rx_bit_d   = rx_bit_q + BIT_W'(1);
                if (rx_bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                    rx_state_d = rx_par_en_q ? R_PARITY : R_STOP;
                end
            end
            R_PARITY: if (rx_done_c) begin
                rx_os_d      = '0;
                rx_par_bit_d = rx_s2;
                rx_state_d   = R_STOP;
            end
            R_STOP: if (rx_done_c) begin
                rx_os_d                 = '0;
                push_c                  = 1'b1;
                push_entry_c.data       = UART_MAX_DATA'(rx_shift_q);
                push_entry_c.frame_err  = !rx_s2;
                push_entry_c.parity_err = rx_par_en_q &&
                    (rx_par_bit_q != uart_parity(UART_MAX_DATA'(rx_shift_q), rx_par_odd_q));
                rx_state_d              = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state_q   <= R_IDLE;
            rx_div_q     <= DIV_WIDTH'(1);
            rx_cnt_q     <= '0;
            rx_os_q      <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bit_q <= 1'b0;
        end else begin
            rx_s1        <= rx_i;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rx_state_q   <= rx_state_d;
            rx_div_q     <= rx_div_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_os_q      <= rx_os_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            rx_par_bit_q <= rx_par_bit_d;
        end
    end

    // ---------------- RX FIFO ----------------
    rx_entry_t head;
    logic      fifo_full_c, fifo_empty_c, fifo_drop_c;
    logic      head_unused;

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_data  (push_entry_c),
        .pop        (rx_ready_i),
        .head_data  (head),
        .head_valid (rx_valid_o),
        .full_c     (fifo_full_c),
        .empty_c    (fifo_empty_c),
        .drop_c     (fifo_drop_c)
    );

    assign rx_data_o       = head.data[DATA_WIDTH-1:0];
    assign rx_parity_err_o = head.parity_err;
    assign rx_frame_err_o  = head.frame_err;
    assign head_unused     = ^{head.data, fifo_full_c, fifo_empty_c};

    // Sticky overrun; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun_o <= 1'b0;
        end else if (fifo_drop_c) begin
            rx_overrun_o <= 1'b1;
        end else if (rx_overrun_clr_i) begin
            rx_overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at baud_div=2 (bit time 32 clk).
module tb_uart_transceiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready, rx_perr, rx_ferr, rx_overrun, rx_overrun_clr;
    logic        tx_line, rx_line, rx_drv, loopback;

    int tests = 0;
    int fails = 0;

    assign rx_line = loopback ? tx_line : rx_drv;

    always #5 clk = ~clk;

    uart_transceiver dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .baud_div_i       (baud_div),
        .parity_en_i      (parity_en),
        .parity_odd_i     (parity_odd),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid),
        .tx_ready_o       (tx_ready),
        .tx_busy_o        (tx_busy),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_ready_i       (rx_ready),
        .rx_parity_err_o  (rx_perr),
        .rx_frame_err_o   (rx_ferr),
        .rx_overrun_o     (rx_overrun),
        .rx_overrun_clr_i (rx_overrun_clr),
        .tx_o             (tx_line),
        .rx_i             (rx_line)
    );

    task automatic drive_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                               input logic stop_bit);
        @(negedge clk) rx_drv = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (32) @(negedge clk);
        end
        if (par_en) begin
            rx_drv = par_bit;
            repeat (32) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (32) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] d);
        bit sent = 1'b0;
        for (int n = 0; n < 1000 && !sent; n++) begin
            @(negedge clk);
            if (tx_ready) begin
                tx_data  = d;
                tx_valid = 1'b1;
                @(posedge clk);
                #1 tx_valid = 1'b0;
                sent = 1'b1;
            end
        end
        tests++;
        if (!sent) begin
            fails++;
            $display("FAIL send_timeout: tx_ready=%0b required 1 within 1000 clk", tx_ready);
        end
    endtask

    task automatic recv_check(input logic [7:0] d, input logic perr, input logic ferr);
        bit got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            got = rx_valid;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rx_timeout: rx_valid=0 required 1 (expecting %02h)", d);
        end else begin
            tests += 3;
            if (rx_data !== d) begin
                fails++;
                $display("FAIL rx_data: got %02h required %02h", rx_data, d);
            end
            if (rx_perr !== perr) begin
                fails++;
                $display("FAIL rx_parity_err (%02h): got %0b required %0b", d, rx_perr, perr);
            end
            if (rx_ferr !== ferr) begin
                fails++;
                $display("FAIL rx_frame_err (%02h): got %0b required %0b", d, rx_ferr, ferr);
            end
            rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests += 6;
        if (tx_line !== 1'b1)   begin fails++; $display("FAIL reset_tx_o: got %0b required 1", tx_line); end
        if (tx_ready !== 1'b1)  begin fails++; $display("FAIL reset_tx_ready: got %0b required 1", tx_ready); end
        if (tx_busy !== 1'b0)   begin fails++; $display("FAIL reset_tx_busy: got %0b required 0", tx_busy); end
        if (rx_valid !== 1'b0)  begin fails++; $display("FAIL reset_rx_valid: got %0b required 0", rx_valid); end
        if (rx_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b required 0", rx_overrun); end
        if ({rx_perr, rx_ferr} !== 2'b00) begin
            fails++; $display("FAIL reset_err_flags: got %02b required 00", {rx_perr, rx_ferr});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tx_frame();
        logic [9:0] exp_bits;
        int         ready_at;
        exp_bits  = {1'b1, 8'hA5, 1'b0};
        ready_at  = 0;
        loopback  = 1'b0;
        parity_en = 1'b0;
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int c = 1; c <= 400 && ready_at == 0; c++) begin
            @(posedge clk);
            #1;
            if (c % 32 == 16 && c / 32 < 10) begin
                tests++;
                if (tx_line !== exp_bits[c / 32]) begin
                    fails++;
                    $display("FAIL tx_bit%0d: got %0b required %0b", c / 32, tx_line, exp_bits[c / 32]);
                end
            end
            if (c == 16) begin
                tests++;
                if (tx_busy !== 1'b1) begin fails++; $display("FAIL tx_busy: got %0b required 1", tx_busy); end
            end
            if (tx_ready === 1'b1) ready_at = c;
        end
        tests++;
        if (ready_at != 320) begin
            fails++;
            $display("FAIL tx_ready_low_time: got %0d required 320", ready_at);
        end
    endtask

    task automatic test_tx_reset_abort();
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        tests++;
        if (tx_line !== 1'b0) begin fails++; $display("FAIL abort_pre_tx_o: got %0b required 0", tx_line); end
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (tx_line !== 1'b1)  begin fails++; $display("FAIL abort_tx_o: got %0b required 1", tx_line); end
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL abort_tx_ready: got %0b required 1", tx_ready); end
        if (tx_busy !== 1'b0)  begin fails++; $display("FAIL abort_tx_busy: got %0b required 0", tx_busy); end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        loopback   = 1'b1;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        send_word(8'h3C);
        send_word(8'hFF);
        recv_check(8'h3C, 1'b0, 1'b0);
        recv_check(8'hFF, 1'b0, 1'b0);
        repeat (400) @(negedge clk);
        loopback = 1'b0;
        repeat (64) @(negedge clk);
    endtask

    task automatic test_parity_err();
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        drive_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        recv_check(8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_frame_err();
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        drive_frame(8'h81, 1'b0, 1'b0, 1'b0);
        recv_check(8'h81, 1'b0, 1'b1);
        drive_frame(8'h55, 1'b0, 1'b0, 1'b1);
        recv_check(8'h55, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        @(negedge clk) rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        tests++;
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_push: rx_valid=%0b required 0", rx_valid); end
        drive_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        recv_check(8'h5A, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) drive_frame(8'(i), 1'b0, 1'b0, 1'b1);
        tests += 2;
        if (rx_overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %0b required 1", rx_overrun); end
        if (rx_data !== 8'h01)   begin fails++; $display("FAIL overrun_head: got %02h required 01", rx_data); end
        for (int i = 1; i <= 4; i++) recv_check(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        tests += 2;
        if (rx_valid !== 1'b0)   begin fails++; $display("FAIL drained_valid: got %0b required 0", rx_valid); end
        if (rx_overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %0b required 1", rx_overrun); end
        rx_overrun_clr = 1'b1;
        @(negedge clk) rx_overrun_clr = 1'b0;
        tests++;
        if (rx_overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr: got %0b required 0", rx_overrun); end
    endtask

    initial begin
        rst_n          = 1'b0;
        baud_div       = 16'd2;
        parity_en      = 1'b0;
        parity_odd     = 1'b0;
        tx_data        = '0;
        tx_valid       = 1'b0;
        rx_ready       = 1'b0;
        rx_overrun_clr = 1'b0;
        rx_drv         = 1'b1;
        loopback       = 1'b0;
        test_reset();
        test_tx_frame();
        test_tx_reset_abort();
        test_back_to_back();
        test_parity_err();
        test_frame_err();
        test_glitch();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
